// File: rtl/nios_mul_pipe.sv
// nios_mul_pipe: two-stage valid/ready Nios II multiplier (mul/mulxuu/mulxss/mulxsu) with tag passthrough and flush.
// Define NIOS_MUL_PIPE_OVF_EN to add out_ovf, set when a MUL result does not fit in the low word.
module nios_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
`ifdef NIOS_MUL_PIPE_OVF_EN
  output logic              out_ovf,
`endif
  output logic [TAG_W-1:0]  out_tag
);
  localparam int H  = DATA_W / 2;
  localparam int PW = 2 * H + 2;
  localparam int W2 = 2 * DATA_W;
  localparam int EW = W2 - PW;
  logic                    s1_valid_q, s2_valid_q, s1_valid_d, s2_valid_d;
  logic                    s1_load, s2_load;
  logic [1:0]              op_q;
  logic [TAG_W-1:0]        tag1_q, tag2_q;
  logic [2*H-1:0]          ll_q, ll_d, al_u, bl_u;
  logic signed [PW-1:0]    lh_q, hl_q, hh_q, lh_d, hl_d, hh_d;
  logic signed [PW-1:0]    al_x, bl_x, ah_x, bh_x;
  logic                    a_sgn, b_sgn;
  logic [W2-1:0]           hh_w, mid_w, ll_w, p;
  logic [DATA_W-1:0]       res_q, res_d;
  assign s2_load    = s1_valid_q & (~s2_valid_q | out_ready) & ~flush;
  assign in_ready   = ~flush & (~s1_valid_q | s2_load);
  assign s1_load    = in_valid & in_ready;
  assign s1_valid_d = ~flush & (s1_load | (s1_valid_q & ~s2_load));
  assign s2_valid_d = ~flush & (s2_load | (s2_valid_q & ~out_ready));
  // Low halves are always unsigned; high halves carry the operand's sign in an extra bit.
  assign a_sgn = in_op[1];
  assign b_sgn = in_op == 2'd2;
  assign al_u  = {{H{1'b0}}, in_a[H-1:0]};
  assign bl_u  = {{H{1'b0}}, in_b[H-1:0]};
  assign al_x  = {{(H+2){1'b0}}, in_a[H-1:0]};
  assign bl_x  = {{(H+2){1'b0}}, in_b[H-1:0]};
  assign ah_x  = {{(H+2){a_sgn & in_a[DATA_W-1]}}, in_a[DATA_W-1:H]};
  assign bh_x  = {{(H+2){b_sgn & in_b[DATA_W-1]}}, in_b[DATA_W-1:H]};
  assign ll_d  = al_u * bl_u;
  assign lh_d  = al_x * bh_x;
  assign hl_d  = ah_x * bl_x;
  assign hh_d  = ah_x * bh_x;
  assign hh_w  = {{EW{hh_q[PW-1]}}, hh_q};
  assign mid_w = {{EW{lh_q[PW-1]}}, lh_q} + {{EW{hl_q[PW-1]}}, hl_q};
  assign ll_w  = {{DATA_W{1'b0}}, ll_q};
  assign p     = (hh_w << (2 * H)) + (mid_w << H) + ll_w;
  assign res_d = op_q == 2'd0 ? p[DATA_W-1:0] : p[W2-1:DATA_W];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      op_q       <= '0;
      tag1_q     <= '0;
      ll_q       <= '0;
      lh_q       <= '0;
      hl_q       <= '0;
      hh_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        op_q   <= in_op;
        tag1_q <= in_tag;
        ll_q   <= ll_d;
        lh_q   <= lh_d;
        hl_q   <= hl_d;
        hh_q   <= hh_d;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      tag2_q     <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        res_q  <= res_d;
        tag2_q <= tag1_q;
      end
    end
  end
`ifdef NIOS_MUL_PIPE_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = (op_q == 2'd0) & (|p[W2-1:DATA_W]);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else if (s2_load) ovf_q <= ovf_d;
  end
  assign out_ovf = ovf_q;
`endif
  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_tag    = tag2_q;
endmodule

// File: tb/tb_nios_mul_pipe.sv
// tb_nios_mul_pipe: scoreboard bench; the driver queues expected results, a monitor pops them on each output transfer.
module tb_nios_mul_pipe;
  logic        clk = 1'b0, reset_n = 1'b1, in_valid = 1'b0, flush = 1'b0;
  logic        in_ready, out_valid, out_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  logic [4:0]  in_tag = '0, out_tag;
`ifdef NIOS_MUL_PIPE_OVF_EN
  logic        out_ovf;
`endif
  logic        rnd_rdy = 1'b0, fixed_rdy = 1'b1, rr = 1'b1;
  int          errors = 0, checks = 0;
  typedef struct packed {logic [31:0] res; logic [4:0] tag; logic ovf;} exp_t;
  exp_t        exp_q[$];
  exp_t        m_e;
  assign out_ready = rnd_rdy ? rr : fixed_rdy;
  always #5 clk = ~clk;
  nios_mul_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
`ifdef NIOS_MUL_PIPE_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_tag(out_tag)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, pr;
    ax = {(op[1] ? {32{a[31]}} : 32'h0), a};
    bx = {(op == 2'd2 ? {32{b[31]}} : 32'h0), b};
    pr = ax * bx;
    return {op == 2'd0 && pr[63:32] != 32'h0, op == 2'd0 ? pr[31:0] : pr[63:32]};
  endfunction
  always @(negedge clk) rr = $urandom_range(0, 3) != 0;
  always @(negedge clk) begin
    #1;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: tag %0d result 0x%08h with nothing outstanding", out_tag, out_result);
      end else begin
        m_e = exp_q.pop_front();
        chk("result", out_result, m_e.res);
        chk("tag", 32'(out_tag), 32'(m_e.tag));
`ifdef NIOS_MUL_PIPE_OVF_EN
        chk("ovf", 32'(out_ovf), 32'(m_e.ovf));
`endif
      end
    end
  end
  // Called at a falling edge; offers one op until accepted, returns at a falling edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] r, input logic ov);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: tag %0d not accepted, in_ready=%0b required 1", tag, in_ready);
    end else exp_q.push_back('{r, tag, ov});
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic lat_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] r, input logic ov);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    chk("lat_accept", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back('{r, tag, ov});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lat_cycle1_idle", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc;
    logic [31:0] held;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    lat_check(2'd0, 32'h00012345, 32'h00000010, 5'd3, 32'h00123450, 1'b0);
    issue(2'd1, 32'hFFFFFFFF, 32'h00000002, 5'd4, 32'h00000001, 1'b0);
    issue(2'd2, 32'hFFFFFFFF, 32'h00000002, 5'd5, 32'hFFFFFFFF, 1'b0);
    issue(2'd3, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, 1'b0);
    issue(2'd0, 32'h00010000, 32'h00010000, 5'd7, 32'h00000000, 1'b1);
    issue(2'd2, 32'h80000000, 32'h80000000, 5'd8, 32'h40000000, 1'b0);
    issue(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'hFFFFFFFF, 1'b0);
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000001, 1'b1);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE, 1'b0);
    issue(2'd3, 32'h00000002, 32'h80000000, 5'd12, 32'h00000001, 1'b0);
    issue(2'd2, 32'h00000002, 32'h80000000, 5'd13, 32'hFFFFFFFF, 1'b0);
    issue(2'd2, 32'hFFFFFFFE, 32'h00000003, 5'd14, 32'hFFFFFFFF, 1'b0);
    drain();
    // Backpressure: only two ops fit while the consumer stalls.
    @(negedge clk);
    fixed_rdy = 1'b0;
    acc = 0;
    held = '0;
    in_valid = 1'b1;
    in_op = 2'd0;
    for (int c = 0; c < 6; c++) begin
      in_a = 32'(acc + 1); in_b = 32'd3; in_tag = 5'(acc);
      #1;
      if (in_ready) begin
        exp_q.push_back('{32'((acc + 1) * 3), 5'(acc), 1'b0});
        acc++;
      end
      if (c == 3) held = out_result;
      if (c == 5) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", out_result, held);
        chk("stall_value", out_result, 32'd3);
      end
      @(negedge clk);
    end
    #1;
    chk("stall_accepted", 32'(acc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    fixed_rdy = 1'b1;
    issue(2'd0, 32'd3, 32'd3, 5'd2, 32'd9, 1'b0);
    issue(2'd0, 32'd4, 32'd3, 5'd3, 32'd12, 1'b0);
    drain();
    // Flush with two ops in flight and a new op offered.
    @(negedge clk);
    fixed_rdy = 1'b0;
    issue(2'd0, 32'd5, 32'd5, 5'd10, 32'd25, 1'b0);
    issue(2'd0, 32'd6, 32'd6, 5'd11, 32'd36, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd12;
    exp_q.delete();
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("preflush_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("postflush_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    fixed_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("postflush_empty", 32'(out_valid), 32'd0);
    @(negedge clk);
    lat_check(2'd0, 32'd6, 32'd7, 5'd13, 32'd42, 1'b0);
    drain();
    // Asynchronous reset with the pipeline full.
    @(negedge clk);
    fixed_rdy = 1'b0;
    issue(2'd0, 32'd5, 32'd7, 5'd20, 32'd35, 1'b0);
    issue(2'd0, 32'd2, 32'd2, 5'd21, 32'd4, 1'b0);
    #1;
    chk("prereset_result", out_result, 32'd35);
    chk("prereset_tag", 32'(out_tag), 32'd20);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_result", out_result, 32'd0);
    chk("async_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fixed_rdy = 1'b1;
    #1;
    chk("rerelease_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    lat_check(2'd0, 32'd9, 32'd9, 5'd22, 32'd81, 1'b0);
    drain();
    // Random-ready soak against the full-width reference.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [32:0] m;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = {a[31], 31'h0};
      m = model(op, a, b);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      issue(op, a, b, 5'(i), m[31:0], m[32]);
    end
    drain();
    rnd_rdy = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
